// File: rtl/i2c_slave_byte_engine.sv
// I2C slave bit engine: synchronises SCL/SDA, detects START/STOP, matches the
// device address, shifts bytes in/out and drives ACK/NACK on open-drain SDA.
module i2c_slave_byte_engine #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2,
  parameter int         FOUND_WAIT  = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       SCL,
  input  logic       SDA_In,
  output logic       SDA_OutEn,
  output logic [7:0] WrData,
  input  logic [7:0] RdData,
  output logic       Enable,
  output logic       Mode,
  output logic       RorW,
  input  logic       AddressFound,
  output logic       Busy
);

  typedef enum logic [3:0] {
    IDLE, DEV_ADDR, DEV_ACK, MEM_ADDR, ADDR_WAIT, MEM_ACK,
    WRITE, WRITE_ACK, READ_LOAD, READ, READ_ACK
  } state_t;

  state_t state;

  logic [SYNC_STAGES-1:0] scl_sy, sda_sy;
  logic       scl_d, sda_d;
  logic       scl_s, sda_s;
  logic       scl_rise, scl_fall, start_c, stop_c;
  logic [3:0] bitcnt;
  logic [7:0] shreg;
  logic [7:0] byte_in;
  logic [7:0] wcnt;
  logic [1:0] ld;
  logic       ph;
  logic       ack_bit;
  logic       byte_done;

  assign scl_s     = scl_sy[SYNC_STAGES-1];
  assign sda_s     = sda_sy[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_c   = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_c    = scl_s & scl_d & ~sda_d & sda_s;
  assign byte_in   = {shreg[6:0], sda_s};
  assign byte_done = scl_rise && (bitcnt == 4'd7);

  // Synchronisers reset to the idle-bus level so reset release
  // never looks like a START or STOP.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      scl_sy <= '1;
      sda_sy <= '1;
      scl_d  <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_sy <= {scl_sy[SYNC_STAGES-2:0], SCL};
      sda_sy <= {sda_sy[SYNC_STAGES-2:0], SDA_In};
      scl_d  <= scl_s;
      sda_d  <= sda_s;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      SDA_OutEn <= 1'b0;
      WrData    <= 8'h00;
      Enable    <= 1'b0;
      Mode      <= 1'b0;
      RorW      <= 1'b0;
      Busy      <= 1'b0;
      bitcnt    <= 4'd0;
      shreg     <= 8'h00;
      wcnt      <= 8'd0;
      ld        <= 2'd0;
      ph        <= 1'b0;
      ack_bit   <= 1'b0;
    end else begin
      Enable <= 1'b0;
      if (start_c) begin
        state     <= DEV_ADDR;
        bitcnt    <= 4'd0;
        SDA_OutEn <= 1'b0;
        ph        <= 1'b0;
      end else if (stop_c) begin
        state     <= IDLE;
        SDA_OutEn <= 1'b0;
        Busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          DEV_ADDR, MEM_ADDR, WRITE: begin
            if (scl_rise) begin
              shreg  <= byte_in;
              bitcnt <= bitcnt + 4'd1;
            end
            if (byte_done) begin
              bitcnt <= 4'd0;
              ph     <= 1'b0;
              unique case (1'b1)
                state == DEV_ADDR: begin
                  if (byte_in[7:1] == SLAVE_ADDR) begin
                    RorW    <= byte_in[0];
                    Busy    <= 1'b1;
                    ack_bit <= 1'b1;
                    state   <= DEV_ACK;
                  end else begin
                    state <= IDLE;
                  end
                end
                state == MEM_ADDR: begin
                  WrData <= byte_in;
                  Mode   <= 1'b0;
                  Enable <= 1'b1;
                  wcnt   <= 8'd1;
                  state  <= ADDR_WAIT;
                end
                default: begin
                  WrData  <= byte_in;
                  Mode    <= 1'b1;
                  RorW    <= 1'b0;
                  Enable  <= 1'b1;
                  ack_bit <= 1'b1;
                  state   <= WRITE_ACK;
                end
              endcase
            end
          end
          ADDR_WAIT: begin
            if (wcnt >= 8'(FOUND_WAIT)) begin
              ack_bit <= AddressFound;
              state   <= MEM_ACK;
            end else begin
              wcnt <= wcnt + 8'd1;
            end
          end
          // First fall after bit 8 opens the ACK slot, second closes it.
          DEV_ACK, MEM_ACK, WRITE_ACK: begin
            if (scl_fall) begin
              if (!ph) begin
                ph        <= 1'b1;
                SDA_OutEn <= ack_bit;
              end else begin
                ph        <= 1'b0;
                SDA_OutEn <= 1'b0;
                ld        <= 2'd0;
                unique case (1'b1)
                  state == DEV_ACK: state <= RorW ? READ_LOAD : MEM_ADDR;
                  state == MEM_ACK: begin
                    state <= ack_bit ? WRITE : IDLE;
                    Busy  <= ack_bit;
                  end
                  default: state <= WRITE;
                endcase
              end
            end
          end
          READ_LOAD: begin
            unique case (ld)
              2'd0: begin
                Enable <= 1'b1;
                Mode   <= 1'b1;
                RorW   <= 1'b1;
                ld     <= 2'd1;
              end
              2'd1: ld <= 2'd2;
              default: begin
                shreg     <= RdData;
                SDA_OutEn <= ~RdData[7];
                bitcnt    <= 4'd0;
                ld        <= 2'd0;
                state     <= READ;
              end
            endcase
          end
          READ: begin
            if (scl_rise) begin
              bitcnt <= bitcnt + 4'd1;
            end else if (scl_fall) begin
              if (bitcnt == 4'd8) begin
                SDA_OutEn <= 1'b0;
                state     <= READ_ACK;
              end else if (bitcnt != 4'd0) begin
                shreg     <= {shreg[6:0], 1'b0};
                SDA_OutEn <= ~shreg[6];
              end
            end
          end
          READ_ACK: begin
            if (scl_rise) begin
              if (sda_s) begin
                state <= IDLE;
                Busy  <= 1'b0;
              end else begin
                bitcnt <= 4'd9;
              end
            end else if (scl_fall && bitcnt == 4'd9) begin
              ld    <= 2'd0;
              state <= READ_LOAD;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_byte_engine.sv
// Bench for i2c_slave_byte_engine: bus-level master tasks plus an
// Enable scoreboard fed by the stimulus and drained by a monitor.
module tb_i2c_slave_byte_engine;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       scl_m, sda_m;
  logic       SDA_OutEn;
  logic [7:0] WrData;
  logic [7:0] RdData;
  logic       Enable, Mode, RorW;
  logic       AddressFound;
  logic       Busy;
  logic       sda_bus;

  localparam int Q = 50;

  assign sda_bus = sda_m & ~SDA_OutEn;

  i2c_slave_byte_engine dut (
    .Clk(Clk),
    .Reset(Reset),
    .SCL(scl_m),
    .SDA_In(sda_bus),
    .SDA_OutEn(SDA_OutEn),
    .WrData(WrData),
    .RdData(RdData),
    .Enable(Enable),
    .Mode(Mode),
    .RorW(RorW),
    .AddressFound(AddressFound),
    .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  // Memory model: each read strobe advances the pointer, so the byte
  // captured one cycle later is the next table entry.
  logic [7:0] rd_mem [0:7];
  int rd_ptr = 0;
  always @(posedge Clk) if (Enable && RorW) rd_ptr <= rd_ptr + 1;
  assign RdData = rd_mem[rd_ptr[2:0]];

  typedef struct packed {
    logic       mode;
    logic       rorw;
    logic       chkdata;
    logic [7:0] data;
  } exp_t;

  exp_t q[$];
  int   n_chk;
  int   n_fail;
  int   drive_cnt;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic m, input logic r, input logic c,
                      input logic [7:0] d);
    exp_t e;
    e.mode = m; e.rorw = r; e.chkdata = c; e.data = d;
    q.push_back(e);
  endtask

  task automatic start_cond();
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b0; #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic stop_cond();
    sda_m = 1'b0; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b1; #(2*Q);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; #Q;
    scl_m = 1'b1; #(2*Q);
    scl_m = 1'b0; #Q;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_ack,
                           input string name);
    logic a;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    a = sda_bus; #Q;
    scl_m = 1'b0; #Q;
    check(name, {31'd0, a}, {31'd0, exp_ack});
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      sda_m = 1'b1; #Q;
      scl_m = 1'b1; #Q;
      d = {d[6:0], sda_bus}; #Q;
      scl_m = 1'b0; #Q;
    end
    sda_m = nack; #Q;
    scl_m = 1'b1; #(2*Q);
    scl_m = 1'b0; #Q;
  endtask

  initial begin
    logic [7:0] d;
    int snap;
    n_chk = 0; n_fail = 0; drive_cnt = 0;
    rd_mem[0] = 8'h00; rd_mem[1] = 8'h96; rd_mem[2] = 8'h5A;
    rd_mem[3] = 8'hC3; rd_mem[4] = 8'h00; rd_mem[5] = 8'h00;
    rd_mem[6] = 8'h00; rd_mem[7] = 8'h00;
    Reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1; AddressFound = 1'b1;

    fork
      begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
      end
      begin
        logic prev_en;
        exp_t e;
        prev_en = 1'b0;
        forever begin
          @(negedge Clk);
          if (SDA_OutEn) drive_cnt++;
          if (Enable) begin
            check("enable_gap", {31'd0, prev_en}, 32'd0);
            if (q.size() == 0) begin
              check("unexpected_enable", 32'd1, 32'd0);
            end else begin
              e = q.pop_front();
              check("sb_mode", {31'd0, Mode}, {31'd0, e.mode});
              check("sb_rorw", {31'd0, RorW}, {31'd0, e.rorw});
              if (e.chkdata)
                check("sb_wrdata", {24'd0, WrData}, {24'd0, e.data});
            end
          end
          prev_en = Enable;
        end
      end
    join_none

    repeat (5) @(posedge Clk);
    #1 Reset = 1'b0;
    repeat (5) @(posedge Clk);
    #1 check("reset_outs",
             {20'd0, SDA_OutEn, WrData, Enable, Mode, RorW, Busy}, 32'd0);

    // Write with address hit
    start_cond();
    send_byte(8'hA0, 1'b0, "wr_dev_ack");
    check("wr_busy", {31'd0, Busy}, 32'd1);
    push(1'b0, 1'b0, 1'b1, 8'h05);
    send_byte(8'h05, 1'b0, "wr_mem_ack");
    push(1'b1, 1'b0, 1'b1, 8'h3C);
    send_byte(8'h3C, 1'b0, "wr_data_ack");
    check("wr_wrdata_hold", {24'd0, WrData}, 32'h3C);
    stop_cond();
    #(2*Q) check("wr_busy_after_stop", {31'd0, Busy}, 32'd0);

    // Foreign device address
    snap = drive_cnt;
    start_cond();
    send_byte(8'hA2, 1'b1, "other_dev_nack");
    check("other_busy", {31'd0, Busy}, 32'd0);
    send_byte(8'h05, 1'b1, "other_byte_nack");
    stop_cond();
    check("other_no_drive", drive_cnt - snap, 32'd0);

    // Memory address miss
    AddressFound = 1'b0;
    start_cond();
    send_byte(8'hA0, 1'b0, "miss_dev_ack");
    push(1'b0, 1'b0, 1'b1, 8'h07);
    send_byte(8'h07, 1'b1, "miss_mem_nack");
    check("miss_busy", {31'd0, Busy}, 32'd0);
    send_byte(8'h3C, 1'b1, "miss_ignored");
    stop_cond();
    AddressFound = 1'b1;

    // Two-byte read
    start_cond();
    push(1'b1, 1'b1, 1'b0, 8'h00);
    push(1'b1, 1'b1, 1'b0, 8'h00);
    send_byte(8'hA1, 1'b0, "rd_dev_ack");
    check("rd_rorw", {31'd0, RorW}, 32'd1);
    read_byte(1'b0, d);
    check("rd_byte0", {24'd0, d}, 32'h96);
    read_byte(1'b1, d);
    check("rd_byte1", {24'd0, d}, 32'h5A);
    check("rd_busy_after_nack", {31'd0, Busy}, 32'd0);
    stop_cond();

    // Repeated START in the middle of a write byte
    start_cond();
    send_byte(8'hA0, 1'b0, "rs_dev_ack");
    push(1'b0, 1'b0, 1'b1, 8'h05);
    send_byte(8'h05, 1'b0, "rs_mem_ack");
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    start_cond();
    push(1'b1, 1'b1, 1'b0, 8'h00);
    send_byte(8'hA1, 1'b0, "rs_dev2_ack");
    check("rs_rorw", {31'd0, RorW}, 32'd1);
    check("rs_busy", {31'd0, Busy}, 32'd1);
    read_byte(1'b1, d);
    check("rs_rd_byte", {24'd0, d}, 32'hC3);
    stop_cond();

    // Reset in the middle of a read byte
    start_cond();
    push(1'b1, 1'b1, 1'b0, 8'h00);
    send_byte(8'hA1, 1'b0, "rst_dev_ack");
    for (int i = 0; i < 4; i++) begin
      sda_m = 1'b1; #Q;
      scl_m = 1'b1; #(2*Q);
      scl_m = 1'b0; #Q;
    end
    check("rst_pre_drive", {31'd0, SDA_OutEn}, 32'd1);
    #3 Reset = 1'b1;
    #1 check("rst_sda_now", {31'd0, SDA_OutEn}, 32'd0);
    check("rst_outs",
          {20'd0, SDA_OutEn, WrData, Enable, Mode, RorW, Busy}, 32'd0);
    scl_m = 1'b1; sda_m = 1'b1;
    repeat (4) @(posedge Clk);
    #1 Reset = 1'b0;
    repeat (8) @(posedge Clk);
    start_cond();
    send_byte(8'hA0, 1'b0, "post_dev_ack");
    push(1'b0, 1'b0, 1'b1, 8'h11);
    send_byte(8'h11, 1'b0, "post_mem_ack");
    push(1'b1, 1'b0, 1'b1, 8'h22);
    send_byte(8'h22, 1'b0, "post_data_ack");
    stop_cond();

    #(4*Q);
    check("sb_drained", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
